uart_frame_parser: RTL and testbench
====================================

// Module: uart_frame_parser
// PURPOSE
//   Consumes the byte stream from the UART receive stage (8-bit data + one-cycle done pulse).
//   Extracts framed commands of the form  A5 | CMD | LEN | PAYLOAD[LEN] | CSUM.
//   Streams payload bytes out, then flags the frame as accepted (frame_ok) or rejected (frame_err).
//   Downstream command logic must discard streamed payload when the frame ends in frame_err.
// PARAMETERS
//   HEADER       8'hA5  start-of-frame byte
//   MAX_LEN      16     max payload length accepted (1..255)
//   TIMEOUT_CYC  43400  max sys_clk cycles between bytes inside a frame (~10 byte times @50MHz/115200)
// PORTS
//   sys_clk     in   1  system clock; everything is rising-edge
//   rst_n       in   1  synchronous active-low reset
//   rx_data     in   8  received byte; valid only in the cycle rx_done=1
//   rx_done     in   1  one-cycle pulse per received byte
//   rx_en       out  1  receive enable to the UART RX stage; 1 whenever out of reset
//   cmd_out     out  8  CMD byte of the current/last frame; held until the next CMD byte
//   len_out     out  8  LEN byte of the current/last frame; held until the next LEN byte
//   pay_data    out  8  payload byte
//   pay_idx     out  8  index of pay_data within the payload, 0-based
//   pay_valid   out  1  one-cycle strobe qualifying pay_data/pay_idx
//   frame_ok    out  1  one-cycle pulse: checksum matched, frame complete
//   frame_err   out  1  one-cycle pulse: frame aborted
//   err_code    out  2  valid with frame_err; held until the next frame_err
//                       1=length>MAX_LEN  2=checksum mismatch  3=inter-byte timeout
// BEHAVIOUR
//   Reset (rst_n=0 at an edge)
//     - All outputs go to 0 except rx_en (1); FSM goes to S_HEAD; sum and timer cleared.
//     - Mid-frame reset drops the partial frame silently; no frame_err is raised.
//   Latency and strobes
//     - Every output is registered; each strobe asserts the cycle after the rx_done that caused it.
//     - pay_valid, frame_ok and frame_err are single-cycle pulses.
//     - frame_ok and frame_err are never asserted together.
//   FSM (transitions only on rx_done=1 unless noted)
//     S_HEAD: rx_data==HEADER -> S_CMD, sum<=0. Any other byte is dropped; no error raised.
//     S_CMD:  cmd_out<=byte, sum<=sum+byte -> S_LEN.
//     S_LEN:  len_out<=byte, sum<=sum+byte.
//             byte>MAX_LEN -> frame_err, code 1, S_HEAD.
//             byte==0 -> S_CSUM.
//             else -> S_DATA, idx<=0.
//     S_DATA: pay_data<=byte, pay_idx<=idx, pay_valid pulse, sum<=sum+byte, idx<=idx+1.
//             Last byte (idx==len_out-1) -> S_CSUM.
//     S_CSUM: byte==sum -> frame_ok. Else frame_err, code 2. Either way -> S_HEAD.
//   Checksum arithmetic
//     - sum is 8-bit, wraps mod 256, and covers CMD, LEN and all payload bytes.
//     - HEADER is excluded; carries are discarded.
//   Timeout
//     - Timer clears on every rx_done and increments each cycle while FSM != S_HEAD.
//     - Timer reaching TIMEOUT_CYC-1 with no rx_done that cycle -> frame_err, code 3, S_HEAD.
//     - rx_done in the expiry cycle wins: the byte is processed and the timer clears.
//     - Timer is held at 0 in S_HEAD.
//   Boundaries
//     - HEADER inside a payload is treated as data; there is no resync mid-frame.
//     - A byte in the cycle after frame_ok/frame_err is evaluated in S_HEAD, so back-to-back frames work.
//     - rx_data is ignored whenever rx_done=0.
// TESTING
//   1. Bytes A5 01 02 10 20 33 -> pay_valid x2 (idx0=10, idx1=20); cmd_out=01, len_out=02; frame_ok once.
//   2. Bytes A5 01 02 10 20 34 -> pay_valid x2, then frame_err with err_code=2; no frame_ok.
//   3. Bytes 00 FF A5 07 00 07 -> leading junk dropped, no pay_valid, frame_ok; cmd_out=07, len_out=00.
//   4. Bytes A5 01 11 (MAX_LEN=16) -> frame_err code 1 after the LEN byte; then A5 02 00 02 -> frame_ok.
//   5. Bytes A5 01, then idle -> frame_err code 3 exactly TIMEOUT_CYC cycles after the 01 byte.
//      Repeat with rx_done landing in the expiry cycle -> no error.
//   6. rst_n low for 1 cycle after A5 01 02 10 -> outputs at reset values, no strobes; then case 1 passes.

Source files
------------

// File: rtl/uart_frame_parser_if.sv
//==============================================================================
// Module : uart_frame_parser_if
// Desc   : Byte-stream input and frame/payload outputs of the UART frame parser.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface uart_frame_parser_if;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_en;
  logic [7:0] cmd_out;
  logic [7:0] len_out;
  logic [7:0] pay_data;
  logic [7:0] pay_idx;
  logic       pay_valid;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;

  // master = byte source / result consumer, slave = the parser itself
  modport master (
    output rx_data, rx_done,
    input  rx_en, cmd_out, len_out, pay_data, pay_idx,
    input  pay_valid, frame_ok, frame_err, err_code
  );

  modport slave (
    input  rx_data, rx_done,
    output rx_en, cmd_out, len_out, pay_data, pay_idx,
    output pay_valid, frame_ok, frame_err, err_code
  );
endinterface

`default_nettype wire

// File: rtl/uart_frame_parser.sv
//==============================================================================
// Module : uart_frame_parser
// Desc   : Parses A5|CMD|LEN|PAYLOAD|CSUM frames from a UART byte stream.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_frame_parser #(
  parameter logic [7:0] HEADER      = 8'hA5,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 43400
) (
  input  wire logic          sys_clk,
  input  wire logic          rst_n,
  uart_frame_parser_if.slave bus
);

  localparam int                 c_TIMER_W   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0]         c_MAX_LEN   = 8'(MAX_LEN);
  localparam logic [1:0]         c_ERR_LEN   = 2'd1;
  localparam logic [1:0]         c_ERR_CSUM  = 2'd2;
  localparam logic [1:0]         c_ERR_TMO   = 2'd3;

  typedef enum logic [2:0] {
    S_HEAD = 3'd0,
    S_CMD  = 3'd1,
    S_LEN  = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4
  } state_t;

  state_t               r_state,     w_state_nxt;
  logic [7:0]           r_sum,       w_sum_nxt;
  logic [7:0]           r_idx,       w_idx_nxt;
  logic [c_TIMER_W-1:0] r_timer,     w_timer_nxt;
  logic [7:0]           r_cmd,       w_cmd_nxt;
  logic [7:0]           r_len,       w_len_nxt;
  logic [7:0]           r_pay_data,  w_pay_data_nxt;
  logic [7:0]           r_pay_idx,   w_pay_idx_nxt;
  logic                 r_pay_valid, w_pay_valid_nxt;
  logic                 r_ok,        w_ok_nxt;
  logic                 r_err,       w_err_nxt;
  logic [1:0]           r_err_code,  w_err_code_nxt;
  logic                 r_rx_en;
  logic [7:0]           w_sum_add;

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      r_state     <= S_HEAD;
      r_sum       <= '0;
      r_idx       <= '0;
      r_timer     <= '0;
      r_cmd       <= '0;
      r_len       <= '0;
      r_pay_data  <= '0;
      r_pay_idx   <= '0;
      r_pay_valid <= 1'b0;
      r_ok        <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= '0;
      r_rx_en     <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_sum       <= w_sum_nxt;
      r_idx       <= w_idx_nxt;
      r_timer     <= w_timer_nxt;
      r_cmd       <= w_cmd_nxt;
      r_len       <= w_len_nxt;
      r_pay_data  <= w_pay_data_nxt;
      r_pay_idx   <= w_pay_idx_nxt;
      r_pay_valid <= w_pay_valid_nxt;
      r_ok        <= w_ok_nxt;
      r_err       <= w_err_nxt;
      r_err_code  <= w_err_code_nxt;
      r_rx_en     <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_sum_nxt       = r_sum;
    w_idx_nxt       = r_idx;
    w_timer_nxt     = r_timer;
    w_cmd_nxt       = r_cmd;
    w_len_nxt       = r_len;
    w_pay_data_nxt  = r_pay_data;
    w_pay_idx_nxt   = r_pay_idx;
    w_pay_valid_nxt = 1'b0;
    w_ok_nxt        = 1'b0;
    w_err_nxt       = 1'b0;
    w_err_code_nxt  = r_err_code;
    w_sum_add       = r_sum + bus.rx_data;

    // A byte arriving in the expiry cycle takes precedence over the timeout.
    if (r_state == S_HEAD || bus.rx_done) begin
      w_timer_nxt = '0;
    end else if (r_timer == c_TIMER_LAST) begin
      w_timer_nxt    = '0;
      w_state_nxt    = S_HEAD;
      w_err_nxt      = 1'b1;
      w_err_code_nxt = c_ERR_TMO;
    end else begin
      w_timer_nxt = r_timer + 1'b1;
    end

    if (bus.rx_done) begin
      case (r_state)
        S_HEAD: begin
          if (bus.rx_data == HEADER) begin
            w_state_nxt = S_CMD;
            w_sum_nxt   = '0;
          end
        end
        S_CMD: begin
          w_cmd_nxt   = bus.rx_data;
          w_sum_nxt   = w_sum_add;
          w_state_nxt = S_LEN;
        end
        S_LEN: begin
          w_len_nxt = bus.rx_data;
          w_sum_nxt = w_sum_add;
          if (bus.rx_data > c_MAX_LEN) begin
            w_err_nxt      = 1'b1;
            w_err_code_nxt = c_ERR_LEN;
            w_state_nxt    = S_HEAD;
          end else if (bus.rx_data == 8'd0) begin
            w_state_nxt = S_CSUM;
          end else begin
            w_idx_nxt   = '0;
            w_state_nxt = S_DATA;
          end
        end
        S_DATA: begin
          w_pay_data_nxt  = bus.rx_data;
          w_pay_idx_nxt   = r_idx;
          w_pay_valid_nxt = 1'b1;
          w_sum_nxt       = w_sum_add;
          w_idx_nxt       = r_idx + 8'd1;
          if (r_idx == r_len - 8'd1) begin
            w_state_nxt = S_CSUM;
          end
        end
        S_CSUM: begin
          if (bus.rx_data == r_sum) begin
            w_ok_nxt = 1'b1;
          end else begin
            w_err_nxt      = 1'b1;
            w_err_code_nxt = c_ERR_CSUM;
          end
          w_state_nxt = S_HEAD;
        end
        default: begin
          w_state_nxt = S_HEAD;
        end
      endcase
    end
  end

  assign bus.rx_en     = r_rx_en;
  assign bus.cmd_out   = r_cmd;
  assign bus.len_out   = r_len;
  assign bus.pay_data  = r_pay_data;
  assign bus.pay_idx   = r_pay_idx;
  assign bus.pay_valid = r_pay_valid;
  assign bus.frame_ok  = r_ok;
  assign bus.frame_err = r_err;
  assign bus.err_code  = r_err_code;

endmodule

`default_nettype wire

// File: tb/tb_uart_frame_parser.sv
//==============================================================================
// Module : tb_uart_frame_parser
// Desc   : Scoreboard bench for uart_frame_parser (short timeout for run time).
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_uart_frame_parser;

  localparam int c_TMO = 64;

  logic clk;
  logic rst_n;
  int   n_run;
  int   n_fail;
  logic mon_en;

  typedef struct packed {
    logic [1:0] kind;   // 0 payload, 1 ok, 2 err
    logic [7:0] a;      // payload idx or err code
    logic [7:0] b;      // payload data
  } ev_t;

  ev_t        sb[$];
  ev_t        mon_got;
  ev_t        mon_exp;
  logic [7:0] tx_q[$];

  uart_frame_parser_if bus ();

  uart_frame_parser #(
    .HEADER      (8'hA5),
    .MAX_LEN     (16),
    .TIMEOUT_CYC (c_TMO)
  ) dut (
    .sys_clk (clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.frame_ok && bus.frame_err) begin
        n_run++;
        n_fail++;
        $display("FAIL ok_err_overlap: frame_ok and frame_err both 1, required exclusive");
      end
      if (bus.pay_valid || bus.frame_ok || bus.frame_err) begin
        mon_got.kind = bus.pay_valid ? 2'd0 : (bus.frame_ok ? 2'd1 : 2'd2);
        mon_got.a    = bus.pay_valid ? bus.pay_idx : (bus.frame_err ? {6'd0, bus.err_code} : 8'd0);
        mon_got.b    = bus.pay_valid ? bus.pay_data : 8'd0;
        n_run++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_strobe: got kind=%0d a=%h b=%h, required none", mon_got.kind, mon_got.a, mon_got.b);
        end else begin
          mon_exp = sb.pop_front();
          if (mon_got !== mon_exp) begin
            n_fail++;
            $display("FAIL strobe: got kind=%0d a=%h b=%h, required kind=%0d a=%h b=%h",
                     mon_got.kind, mon_got.a, mon_got.b, mon_exp.kind, mon_exp.a, mon_exp.b);
          end
        end
      end
    end
  end

  function automatic void push_pay(input logic [7:0] idx, input logic [7:0] data);
    sb.push_back('{kind: 2'd0, a: idx, b: data});
  endfunction

  function automatic void push_ok();
    sb.push_back('{kind: 2'd1, a: 8'd0, b: 8'd0});
  endfunction

  function automatic void push_err(input logic [1:0] code);
    sb.push_back('{kind: 2'd2, a: {6'd0, code}, b: 8'd0});
  endfunction

  // gap = idle cycles between bytes; 0 gives rx_done on consecutive cycles
  task automatic send_q(input int gap);
    while (tx_q.size() > 0) begin
      @(negedge clk);
      bus.rx_data = tx_q.pop_front();
      bus.rx_done = 1'b1;
      if (gap > 0) begin
        @(negedge clk);
        bus.rx_done = 1'b0;
        bus.rx_data = 8'($urandom);
        repeat (gap - 1) @(negedge clk);
      end
    end
    @(negedge clk);
    bus.rx_done = 1'b0;
    bus.rx_data = 8'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_run++;
    if ({bus.cmd_out, bus.len_out, bus.pay_data, bus.pay_idx} !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %h, required 0", {bus.cmd_out, bus.len_out, bus.pay_data, bus.pay_idx});
    end
    n_run++;
    if ({bus.pay_valid, bus.frame_ok, bus.frame_err, bus.err_code} !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b, required 0", {bus.pay_valid, bus.frame_ok, bus.frame_err, bus.err_code});
    end
    n_run++;
    if (bus.rx_en !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_rx_en: got %b, required 1", bus.rx_en);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_good_frame();
    tx_q = '{8'hA5, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33};
    push_pay(8'd0, 8'h10);
    push_pay(8'd1, 8'h20);
    push_ok();
    send_q(1);
    repeat (4) @(negedge clk);
    n_run++;
    if ({bus.cmd_out, bus.len_out} !== 16'h0102) begin
      n_fail++;
      $display("FAIL good_cmd_len: got %h, required 0102", {bus.cmd_out, bus.len_out});
    end
    n_run++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL good_pending: got %0d outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_bad_csum();
    tx_q = '{8'hA5, 8'h01, 8'h02, 8'h10, 8'h20, 8'h34};
    push_pay(8'd0, 8'h10);
    push_pay(8'd1, 8'h20);
    push_err(2'd2);
    send_q(2);
    repeat (4) @(negedge clk);
    n_run++;
    if (bus.err_code !== 2'd2) begin
      n_fail++;
      $display("FAIL csum_code_held: got %0d, required 2", bus.err_code);
    end
    n_run++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL csum_pending: got %0d outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_junk_zero_len();
    tx_q = '{8'h00, 8'hFF, 8'hA5, 8'h07, 8'h00, 8'h07};
    push_ok();
    send_q(1);
    repeat (4) @(negedge clk);
    n_run++;
    if ({bus.cmd_out, bus.len_out} !== 16'h0700) begin
      n_fail++;
      $display("FAIL junk_cmd_len: got %h, required 0700", {bus.cmd_out, bus.len_out});
    end
    n_run++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL junk_pending: got %0d outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_len_limit();
    tx_q = '{8'hA5, 8'h01, 8'h11};
    push_err(2'd1);
    send_q(1);
    repeat (2) @(negedge clk);
    n_run++;
    if (bus.len_out !== 8'h11) begin
      n_fail++;
      $display("FAIL len_out_oversize: got %h, required 11", bus.len_out);
    end
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h02};
    push_ok();
    send_q(1);
    repeat (4) @(negedge clk);
    n_run++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL len_pending: got %0d outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_timeout();
    int seen;
    push_err(2'd3);
    tx_q = '{8'hA5, 8'h01};
    send_q(1);
    // 01 was sampled one edge ago; count edges until frame_err appears
    seen = 0;
    for (int k = 2; k <= c_TMO + 6; k++) begin
      @(posedge clk);
      #1;
      if (bus.frame_err && seen == 0) seen = k;
    end
    n_run++;
    if (seen != c_TMO) begin
      n_fail++;
      $display("FAIL timeout_latency: got edge %0d, required %0d", seen, c_TMO);
    end
    n_run++;
    if (bus.err_code !== 2'd3) begin
      n_fail++;
      $display("FAIL timeout_code: got %0d, required 3", bus.err_code);
    end

    // Second pass: LEN byte lands exactly in the expiry cycle.
    @(negedge clk);
    bus.rx_data = 8'hA5; bus.rx_done = 1'b1;
    @(negedge clk);
    bus.rx_done = 1'b0;
    @(negedge clk);
    bus.rx_data = 8'h01; bus.rx_done = 1'b1;
    @(negedge clk);
    bus.rx_done = 1'b0;
    repeat (c_TMO - 1) @(negedge clk);
    bus.rx_data = 8'h00; bus.rx_done = 1'b1;
    @(negedge clk);
    bus.rx_done = 1'b0;
    n_run++;
    if (bus.len_out !== 8'h00) begin
      n_fail++;
      $display("FAIL expiry_byte_taken: got len %h, required 00", bus.len_out);
    end
    push_ok();
    tx_q = '{8'h01};
    send_q(1);
    repeat (4) @(negedge clk);
    n_run++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL timeout_pending: got %0d outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_mid_reset();
    tx_q = '{8'hA5, 8'h01, 8'h02, 8'h10};
    push_pay(8'd0, 8'h10);
    send_q(1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_run++;
    if ({bus.cmd_out, bus.len_out, bus.pay_data, bus.pay_idx, bus.err_code} !== 34'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %h, required 0",
               {bus.cmd_out, bus.len_out, bus.pay_data, bus.pay_idx, bus.err_code});
    end
    n_run++;
    if (bus.rx_en !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_rx_en: got %b, required 1", bus.rx_en);
    end
    test_good_frame();
  endtask

  task automatic test_back_to_back();
    // header value inside payload is plain data; next frame follows with no gap
    tx_q = '{8'hA5, 8'h03, 8'h02, 8'hA5, 8'h10, 8'hBA, 8'hA5, 8'h04, 8'h00, 8'h04};
    push_pay(8'd0, 8'hA5);
    push_pay(8'd1, 8'h10);
    push_ok();
    push_ok();
    send_q(0);
    repeat (4) @(negedge clk);
    n_run++;
    if ({bus.cmd_out, bus.len_out} !== 16'h0400) begin
      n_fail++;
      $display("FAIL b2b_cmd_len: got %h, required 0400", {bus.cmd_out, bus.len_out});
    end
    n_run++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_pending: got %0d outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_random_frames();
    logic [7:0] cmd;
    logic [7:0] len;
    logic [7:0] sum;
    logic [7:0] d;
    for (int i = 0; i < 8; i++) begin
      cmd = 8'($urandom);
      len = (i == 0) ? 8'd16 : 8'($urandom_range(0, 16));
      sum = cmd + len;
      tx_q.push_back(8'hA5);
      tx_q.push_back(cmd);
      tx_q.push_back(len);
      for (int j = 0; j < int'(len); j++) begin
        d = 8'($urandom);
        sum = sum + d;
        tx_q.push_back(d);
        push_pay(8'(j), d);
      end
      tx_q.push_back(sum);
      push_ok();
      send_q($urandom_range(0, 2));
      repeat (3) @(negedge clk);
      n_run++;
      if ({bus.cmd_out, bus.len_out} !== {cmd, len}) begin
        n_fail++;
        $display("FAIL rand_cmd_len[%0d]: got %h, required %h", i, {bus.cmd_out, bus.len_out}, {cmd, len});
      end
    end
    n_run++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL rand_pending: got %0d outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    n_run       = 0;
    n_fail      = 0;
    mon_en      = 1'b0;
    rst_n       = 1'b0;
    bus.rx_data = 8'h00;
    bus.rx_done = 1'b0;
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_junk_zero_len();
    test_len_limit();
    test_timeout();
    test_mid_reset();
    test_back_to_back();
    test_random_frames();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
